player_damage_tracker: RTL and testbench

Per-player stage directly downstream of the damage coprocessor. Consumes each qualified hit's damage value and accumulates the player's percent, saturating at MAX_PERCENT. Computes a signed knockback vector from the post-hit percent and the damage. Runs the hitstun/invulnerability state machine that gates player control in the movement logic.

---
 rtl/player_damage_tracker.sv | 211 +++++++++++++++++++++
 tb/tb_player_damage_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_damage_tracker.sv
// ---------------------------------------------------------------------------
// player_damage_tracker
//
// Per-player stage that sits directly after the damage coprocessor.
//   * Accumulates the player's damage percent, saturating at MAX_PERCENT.
//   * Turns each accepted hit into a signed knockback vector. The vector
//     appears one cycle after the hit and is computed from the post-hit
//     percent and the clamped damage.
//   * Runs the IDLE / HITSTUN / INVULN state machine. The movement logic
//     uses its outputs to gate player control.
//
// Ports
//   i_clock          system clock, all state on rising edge
//   i_reset          asynchronous, active-high, clears all state
//   i_hit_valid      one-cycle qualifier for i_damage
//   i_damage         unsigned damage from the coprocessor (32 bits)
//   i_attacker_left  1 = knock toward +x, 0 = knock toward -x
//   i_respawn        one-cycle pulse on stock loss / respawn
//   o_percent        accumulated damage percent (10 bits)
//   o_kb_valid       one-cycle pulse, knockback vector valid
//   o_knockback_x    signed horizontal knockback (16 bits)
//   o_knockback_y    vertical knockback, never negative (16 bits)
//   o_hitstun        high while the player is in hitstun
//   o_invuln         high while the player is invulnerable
// ---------------------------------------------------------------------------
module player_damage_tracker #(
    parameter int unsigned MAX_PERCENT   = 999,
    parameter int unsigned BASE_KB       = 8,
    parameter int unsigned KB_SHIFT      = 4,
    parameter int unsigned HS_SHIFT      = 3,
    parameter int unsigned INVULN_CYCLES = 120
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_hit_valid,
    input  logic [31:0] i_damage,
    input  logic        i_attacker_left,
    input  logic        i_respawn,
    output logic [9:0]  o_percent,
    output logic        o_kb_valid,
    output logic [15:0] o_knockback_x,
    output logic [15:0] o_knockback_y,
    output logic        o_hitstun,
    output logic        o_invuln
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HITSTUN = 2'd1;
    localparam logic [1:0] ST_INVULN  = 2'd2;

    localparam logic [9:0]  MAX_PCT     = 10'(MAX_PERCENT);
    localparam logic [31:0] MAX_PCT32   = 32'(MAX_PERCENT);
    localparam logic [31:0] MAG_SAT     = 32'd32767;
    localparam logic [15:0] INVULN_LOAD = 16'(INVULN_CYCLES);

    // Control state
    logic [1:0]  r_state;
    logic [7:0]  r_hitstunCnt;
    logic [15:0] r_invulnCnt;

    // Percent accumulator
    logic [9:0]  r_percent;

    // Stage-1 pipeline registers: the hit waiting for its knockback
    logic        r_s1Valid;
    logic [9:0]  r_s1Pct;
    logic [9:0]  r_s1Dmg;
    logic        r_s1Left;

    // Stage-2 output registers
    logic        r_kbValid;
    logic [15:0] r_kbX;
    logic [15:0] r_kbY;

    // Combinational helpers
    logic        w_hitAccept;
    logic [9:0]  w_dmgClamped;
    logic [10:0] w_pctSum;
    logic [9:0]  w_pctNext;
    logic [19:0] w_product;
    logic [31:0] w_magRaw;
    logic [15:0] w_mag;
    logic [15:0] w_hsShifted;
    logic [7:0]  w_hsLoad;
    logic [15:0] w_kbX;
    logic [15:0] w_kbY;

    // Hits are refused while invulnerable. A respawn in the same cycle
    // also refuses the hit, because the respawn takes priority.
    assign w_hitAccept = i_hit_valid && (i_damage != 32'd0) &&
                         (r_state != ST_INVULN) && !i_respawn;

    // Clamp the damage first, then add it to the percent and saturate.
    // The 11-bit sum cannot overflow because both operands are at most
    // MAX_PERCENT.
    assign w_dmgClamped = (i_damage > MAX_PCT32) ? MAX_PCT : i_damage[9:0];
    assign w_pctSum     = {1'b0, r_percent} + {1'b0, w_dmgClamped};
    assign w_pctNext    = (w_pctSum > {1'b0, MAX_PCT}) ? MAX_PCT : w_pctSum[9:0];

    // Knockback magnitude. The 10x10 product fits 20 bits, and the result
    // saturates so that both +mag and -mag fit in 16-bit two's complement.
    assign w_product = 20'(r_s1Pct) * 20'(r_s1Dmg);
    assign w_magRaw  = 32'(BASE_KB) + 32'(w_product >> KB_SHIFT);
    assign w_mag     = (w_magRaw > MAG_SAT) ? 16'h7FFF : w_magRaw[15:0];

    // Hitstun length is clamped to at least one cycle, so that every
    // accepted hit produces visible stun, and to at most the counter range.
    assign w_hsShifted = w_mag >> HS_SHIFT;
    assign w_hsLoad    = (w_hsShifted == 16'd0)   ? 8'd1  :
                         (w_hsShifted > 16'd255)  ? 8'hFF : w_hsShifted[7:0];

    assign w_kbX = r_s1Left ? w_mag : (16'd0 - w_mag);
    assign w_kbY = {1'b0, w_mag[15:1]};

    // Stage 1: accumulate the percent and capture the values that the
    // knockback computation needs on the next edge. A respawn wipes the
    // percent and drops any hit still in flight.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_percent <= 10'd0;
            r_s1Valid <= 1'b0;
            r_s1Pct   <= 10'd0;
            r_s1Dmg   <= 10'd0;
            r_s1Left  <= 1'b0;
        end else if (i_respawn) begin
            r_percent <= 10'd0;
            r_s1Valid <= 1'b0;
        end else begin
            r_s1Valid <= w_hitAccept;
            if (w_hitAccept) begin
                r_percent <= w_pctNext;
                r_s1Pct   <= w_pctNext;
                r_s1Dmg   <= w_dmgClamped;
                r_s1Left  <= i_attacker_left;
            end
        end
    end

    // Stage 2: publish the knockback vector for one cycle. When no new
    // vector is issued, the vector registers keep their last value.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_kbValid <= 1'b0;
            r_kbX     <= 16'd0;
            r_kbY     <= 16'd0;
        end else begin
            r_kbValid <= r_s1Valid && !i_respawn;
            if (r_s1Valid && !i_respawn) begin
                r_kbX <= w_kbX;
                r_kbY <= w_kbY;
            end
        end
    end

    // State machine and its counters. Priority order:
    //   1. Respawn: enter INVULN and reload the invulnerability timer.
    //   2. A completed stage-2 hit: reload hitstun. Combos replace the
    //      remaining count; they do not add to it.
    //   3. Otherwise count down. The state leaves on the edge where the
    //      counter goes from 1 to 0, so the flag is high for exactly the
    //      loaded number of cycles.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_hitstunCnt <= 8'd0;
            r_invulnCnt  <= 16'd0;
        end else if (i_respawn) begin
            r_state      <= ST_INVULN;
            r_hitstunCnt <= 8'd0;
            r_invulnCnt  <= INVULN_LOAD;
        end else if (r_s1Valid) begin
            r_state      <= ST_HITSTUN;
            r_hitstunCnt <= w_hsLoad;
        end else begin
            case (r_state)
                ST_HITSTUN: begin
                    if (r_hitstunCnt <= 8'd1) begin
                        r_state      <= ST_IDLE;
                        r_hitstunCnt <= 8'd0;
                    end else begin
                        r_hitstunCnt <= r_hitstunCnt - 8'd1;
                    end
                end
                ST_INVULN: begin
                    if (r_invulnCnt <= 16'd1) begin
                        r_state     <= ST_IDLE;
                        r_invulnCnt <= 16'd0;
                    end else begin
                        r_invulnCnt <= r_invulnCnt - 16'd1;
                    end
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_hitstunCnt <= 8'd0;
                    r_invulnCnt  <= 16'd0;
                end
            endcase
        end
    end

    assign o_percent     = r_percent;
    assign o_kb_valid    = r_kbValid;
    assign o_knockback_x = r_kbX;
    assign o_knockback_y = r_kbY;
    assign o_hitstun     = (r_state == ST_HITSTUN);
    assign o_invuln      = (r_state == ST_INVULN);

endmodule

// File: tb/tb_player_damage_tracker.sv
// ---------------------------------------------------------------------------
// tb_player_damage_tracker
//
// Directed testbench for player_damage_tracker. Inputs are driven 1 ns after
// each rising edge and outputs are sampled at that same point. All expected
// values are computed by hand from the behaviour of the block.
// ---------------------------------------------------------------------------
module tb_player_damage_tracker;

    logic        clock;
    logic        reset;
    logic        hit_valid;
    logic [31:0] damage;
    logic        attacker_left;
    logic        respawn;
    logic [9:0]  percent;
    logic        kb_valid;
    logic [15:0] knockback_x;
    logic [15:0] knockback_y;
    logic        hitstun;
    logic        invuln;

    int total = 0;
    int bad   = 0;

    player_damage_tracker dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_hit_valid     (hit_valid),
        .i_damage        (damage),
        .i_attacker_left (attacker_left),
        .i_respawn       (respawn),
        .o_percent       (percent),
        .o_kb_valid      (kb_valid),
        .o_knockback_x   (knockback_x),
        .o_knockback_y   (knockback_y),
        .o_hitstun       (hitstun),
        .o_invuln        (invuln)
    );

    // 100 MHz free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something wedges
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one hit for exactly one edge (edge N), then deassert
    task automatic applyHit(input logic [31:0] dmg, input logic left);
        hit_valid     = 1'b1;
        damage        = dmg;
        attacker_left = left;
        tick();
        hit_valid = 1'b0;
        damage    = 32'd0;
    endtask

    // Count the cycles a flag stays high, starting at the current sample.
    // The count is capped so that a stuck flag cannot hang the run.
    task automatic countHigh(input bit selInvuln, output int n);
        n = 0;
        while (((selInvuln ? invuln : hitstun) === 1'b1) && (n < 1000)) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; hit_valid = 1'b0; damage = 32'd0; attacker_left = 1'b0; respawn = 1'b0;
        tick(); tick();
        total++; if (percent !== 10'd0) begin bad++; $display("[TB] FAIL reset_percent got=%0d want=0", percent); end
        total++; if (kb_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_kb_valid got=%b want=0", kb_valid); end
        total++; if (knockback_x !== 16'd0 || knockback_y !== 16'd0) begin bad++; $display("[TB] FAIL reset_kb got=%0d,%0d want=0,0", knockback_x, knockback_y); end
        total++; if (hitstun !== 1'b0 || invuln !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b%b want=00", hitstun, invuln); end
        reset = 1'b0;
        tick();
        total++; if (percent !== 10'd0 || kb_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset got=%0d/%b want=0/0", percent, kb_valid); end
    endtask

    task automatic test_basic();
        int n;
        applyHit(32'd10, 1'b0);
        total++; if (percent !== 10'd10) begin bad++; $display("[TB] FAIL basic1_percent got=%0d want=10", percent); end
        total++; if (kb_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic1_kb_early got=%b want=0", kb_valid); end
        tick();
        total++; if (kb_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic1_kb_valid got=%b want=1", kb_valid); end
        total++; if (knockback_x !== -16'sd14) begin bad++; $display("[TB] FAIL basic1_kbx got=%0d want=-14", $signed(knockback_x)); end
        total++; if (knockback_y !== 16'd7) begin bad++; $display("[TB] FAIL basic1_kby got=%0d want=7", knockback_y); end
        countHigh(1'b0, n);
        total++; if (n != 1) begin bad++; $display("[TB] FAIL basic1_hitstun_len got=%0d want=1", n); end
        total++; if (kb_valid !== 1'b0 || knockback_x !== -16'sd14) begin bad++; $display("[TB] FAIL basic1_kb_hold got=%b/%0d want=0/-14", kb_valid, $signed(knockback_x)); end

        applyHit(32'd30, 1'b1);
        total++; if (percent !== 10'd40) begin bad++; $display("[TB] FAIL basic2_percent got=%0d want=40", percent); end
        tick();
        total++; if (kb_valid !== 1'b1 || knockback_x !== 16'd83) begin bad++; $display("[TB] FAIL basic2_kbx got=%b/%0d want=1/83", kb_valid, $signed(knockback_x)); end
        total++; if (knockback_y !== 16'd41) begin bad++; $display("[TB] FAIL basic2_kby got=%0d want=41", knockback_y); end
        countHigh(1'b0, n);
        total++; if (n != 10) begin bad++; $display("[TB] FAIL basic2_hitstun_len got=%0d want=10", n); end
    endtask

    task automatic test_saturation();
        int n;
        // Bring the percent from 40 to 990; this hit already saturates the magnitude
        applyHit(32'd950, 1'b1);
        total++; if (percent !== 10'd990) begin bad++; $display("[TB] FAIL sat_prep_percent got=%0d want=990", percent); end
        tick();
        countHigh(1'b0, n);
        total++; if (n != 255) begin bad++; $display("[TB] FAIL sat_prep_hitstun got=%0d want=255", n); end

        applyHit(32'd20, 1'b1);
        total++; if (percent !== 10'd999) begin bad++; $display("[TB] FAIL sat_percent got=%0d want=999", percent); end
        tick();
        total++; if (knockback_x !== 16'd1256 || knockback_y !== 16'd628) begin bad++; $display("[TB] FAIL sat_kb got=%0d,%0d want=1256,628", $signed(knockback_x), knockback_y); end
        countHigh(1'b0, n);
        total++; if (n != 157) begin bad++; $display("[TB] FAIL sat_hitstun got=%0d want=157", n); end

        applyHit(32'd5000, 1'b0);
        total++; if (percent !== 10'd999) begin bad++; $display("[TB] FAIL sat_big_percent got=%0d want=999", percent); end
        tick();
        total++; if (knockback_x !== -16'sd32767) begin bad++; $display("[TB] FAIL sat_big_kbx got=%0d want=-32767", $signed(knockback_x)); end
        total++; if (knockback_y !== 16'd16383) begin bad++; $display("[TB] FAIL sat_big_kby got=%0d want=16383", knockback_y); end
        countHigh(1'b0, n);
        total++; if (n != 255) begin bad++; $display("[TB] FAIL sat_big_hitstun got=%0d want=255", n); end
    endtask

    task automatic test_respawn();
        int n;
        // Put a hit in flight, then respawn together with a new hit on the next edge
        applyHit(32'd5, 1'b1);
        respawn = 1'b1; hit_valid = 1'b1; damage = 32'd50;
        tick();
        respawn = 1'b0; hit_valid = 1'b1; damage = 32'd7; attacker_left = 1'b1;
        total++; if (percent !== 10'd0) begin bad++; $display("[TB] FAIL resp_percent got=%0d want=0", percent); end
        total++; if (kb_valid !== 1'b0) begin bad++; $display("[TB] FAIL resp_kb_dropped got=%b want=0", kb_valid); end
        total++; if (invuln !== 1'b1 || hitstun !== 1'b0) begin bad++; $display("[TB] FAIL resp_flags got=%b%b want=10", invuln, hitstun); end
        // A hit is held on the input for the whole window
        countHigh(1'b1, n);
        total++; if (n != 120) begin bad++; $display("[TB] FAIL resp_invuln_len got=%0d want=120", n); end
        total++; if (percent !== 10'd0) begin bad++; $display("[TB] FAIL resp_window_percent got=%0d want=0", percent); end
        tick();
        hit_valid = 1'b0; damage = 32'd0;
        total++; if (percent !== 10'd7) begin bad++; $display("[TB] FAIL resp_after_percent got=%0d want=7", percent); end
        tick();
        total++; if (kb_valid !== 1'b1 || knockback_x !== 16'd11 || knockback_y !== 16'd5) begin bad++; $display("[TB] FAIL resp_after_kb got=%b/%0d,%0d want=1/11,5", kb_valid, $signed(knockback_x), knockback_y); end
        countHigh(1'b0, n);
        total++; if (n != 1) begin bad++; $display("[TB] FAIL resp_after_hitstun got=%0d want=1", n); end
    endtask

    task automatic test_combo();
        int n;
        reset = 1'b1; #1; reset = 1'b0;
        tick();
        applyHit(32'd30, 1'b0);
        total++; if (percent !== 10'd30) begin bad++; $display("[TB] FAIL combo1_percent got=%0d want=30", percent); end
        tick();
        total++; if (kb_valid !== 1'b1 || knockback_x !== -16'sd64) begin bad++; $display("[TB] FAIL combo1_kbx got=%b/%0d want=1/-64", kb_valid, $signed(knockback_x)); end
        tick(); tick();
        applyHit(32'd10, 1'b0);
        total++; if (percent !== 10'd40 || hitstun !== 1'b1) begin bad++; $display("[TB] FAIL combo2_percent got=%0d/%b want=40/1", percent, hitstun); end
        tick();
        total++; if (kb_valid !== 1'b1 || knockback_x !== -16'sd33 || knockback_y !== 16'd16) begin bad++; $display("[TB] FAIL combo2_kb got=%b/%0d,%0d want=1/-33,16", kb_valid, $signed(knockback_x), knockback_y); end
        countHigh(1'b0, n);
        total++; if (n != 4) begin bad++; $display("[TB] FAIL combo2_hitstun got=%0d want=4", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        hit_valid = 1'b1; damage = 32'd10; attacker_left = 1'b1;
        tick();
        total++; if (percent !== 10'd50) begin bad++; $display("[TB] FAIL b2b_first_percent got=%0d want=50", percent); end
        damage = 32'd20;
        tick();
        hit_valid = 1'b0; damage = 32'd0;
        total++; if (percent !== 10'd70) begin bad++; $display("[TB] FAIL b2b_second_percent got=%0d want=70", percent); end
        total++; if (kb_valid !== 1'b1 || knockback_x !== 16'd39) begin bad++; $display("[TB] FAIL b2b_first_kb got=%b/%0d want=1/39", kb_valid, $signed(knockback_x)); end
        tick();
        total++; if (kb_valid !== 1'b1 || knockback_x !== 16'd95 || knockback_y !== 16'd47) begin bad++; $display("[TB] FAIL b2b_second_kb got=%b/%0d,%0d want=1/95,47", kb_valid, $signed(knockback_x), knockback_y); end
        countHigh(1'b0, n);
        total++; if (n != 11) begin bad++; $display("[TB] FAIL b2b_hitstun got=%0d want=11", n); end
    endtask

    task automatic test_reset_mid();
        bit sawKb;
        // Reset between stage 1 and stage 2
        applyHit(32'd30, 1'b1);
        reset = 1'b1; #1;
        total++; if (percent !== 10'd0 || kb_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_pipe_now got=%0d/%b want=0/0", percent, kb_valid); end
        total++; if (knockback_x !== 16'd0 || knockback_y !== 16'd0) begin bad++; $display("[TB] FAIL rmid_pipe_kb got=%0d,%0d want=0,0", knockback_x, knockback_y); end
        tick();
        reset = 1'b0;
        sawKb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (kb_valid !== 1'b0) sawKb = 1'b1;
        end
        total++; if (sawKb) begin bad++; $display("[TB] FAIL rmid_pipe_release got=1 want=0"); end

        // Reset in the middle of hitstun
        applyHit(32'd30, 1'b0);
        tick(); tick(); tick();
        total++; if (hitstun !== 1'b1) begin bad++; $display("[TB] FAIL rmid_hs_pre got=%b want=1", hitstun); end
        reset = 1'b1; #1;
        total++; if (hitstun !== 1'b0 || percent !== 10'd0 || knockback_x !== 16'd0) begin bad++; $display("[TB] FAIL rmid_hs_now got=%b/%0d/%0d want=0/0/0", hitstun, percent, knockback_x); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (hitstun !== 1'b0 || kb_valid !== 1'b0 || invuln !== 1'b0) begin bad++; $display("[TB] FAIL rmid_hs_release got=%b%b%b want=000", hitstun, kb_valid, invuln); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_respawn();
        test_combo();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
